// File: rtl/gb_video_pkg.sv
// Shared constants, colour type and shade palettes for the Game Boy -> HDMI scaler.
package gb_video_pkg;

  localparam int GB_W      = 160;
  localparam int GB_H      = 144;
  localparam int SCALE     = 3;
  localparam int LOOKAHEAD = 3;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;

  typedef logic [23:0] rgb_t;

  // Index is the 2-bit framebuffer shade, 0 = lightest.
  localparam rgb_t PALETTE_GRAY [4] = '{24'hFFFFFF, 24'hAAAAAA, 24'h555555, 24'h000000};
  localparam rgb_t PALETTE_DMG  [4] = '{24'h9BBC0F, 24'h8BAC0F, 24'h306230, 24'h0F380F};

endpackage

// File: rtl/gb_video_scaler_if.sv
// Framebuffer read port between the scaler (master) and the framebuffer RAM (slave).
interface gb_video_scaler_if;

  logic [15:0] fb_rd_addr;
  logic        fb_rd_en;
  logic [1:0]  fb_rd_data;

  modport master (output fb_rd_addr, output fb_rd_en, input  fb_rd_data);
  modport slave  (input  fb_rd_addr, input  fb_rd_en, output fb_rd_data);

endinterface

// File: rtl/gb_scale_counter.sv
// One axis of the 3x scaler: a source-pixel count plus a sub-pixel phase 0..SCALE-1.
module gb_scale_counter
  import gb_video_pkg::*;
(
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       load_i,
  input  logic       advance_i,
  output logic [7:0] count_o,
  output logic [1:0] sub_o
);

  localparam logic [1:0] SubMax = 2'(SCALE - 1);

  logic [7:0] count_q, count_d;
  logic [1:0] sub_q, sub_d;

  always_comb begin
    count_d = count_q;
    sub_d   = sub_q;
    if (load_i) begin
      count_d = '0;
      sub_d   = '0;
    end else if (advance_i) begin
      if (sub_q == SubMax) begin
        sub_d   = '0;
        count_d = count_q + 8'd1;
      end else begin
        sub_d = sub_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      count_q <= '0;
      sub_q   <= '0;
    end else begin
      count_q <= count_d;
      sub_q   <= sub_d;
    end
  end

  // The next-state view is exported so the caller can register the coordinate of the current look-ahead pixel.
  assign count_o = count_d;
  assign sub_o   = sub_d;

endmodule

// File: rtl/gb_video_scaler.sv
// Scales the 160x144 Game Boy picture 3x into a 640x480 HDMI raster with a 3-edge pipeline.
// Define GB_SCALER_DMG_PALETTE_EN for the green DMG palette instead of grey.
module gb_video_scaler
  import gb_video_pkg::*;
#(
  parameter rgb_t BORDER_RGB = 24'h000000,
  parameter int   WIN_X0     = 80,
  parameter int   WIN_Y0     = 24
) (
  input  logic                      clk_pixel,
  input  logic                      reset,
  input  logic [9:0]                cx,
  input  logic [9:0]                cy,
  gb_video_scaler_if.master         fb,
  output rgb_t                      rgb
);

`ifdef GB_SCALER_DMG_PALETTE_EN
  localparam rgb_t Palette [4] = PALETTE_DMG;
`else
  localparam rgb_t Palette [4] = PALETTE_GRAY;
`endif

  localparam logic [9:0] WinX0  = 10'(WIN_X0);
  localparam logic [9:0] WinX1  = 10'(WIN_X0 + GB_W * SCALE);
  localparam logic [9:0] WinY0  = 10'(WIN_Y0);
  localparam logic [9:0] WinY1  = 10'(WIN_Y0 + GB_H * SCALE);
  localparam logic [9:0] HTotal = 10'(H_TOTAL);

  logic [9:0]  cxSum, cxLa;
  logic        xInWin, yInWin, inWin, lineStart, yLoad, yAdvance;
  logic [7:0]  gbX, gbY;
  logic [1:0]  xSub, ySub;
  logic        unusedSubs;

  logic [15:0] fbRdAddr_q, fbRdAddr_d;
  logic        fbRdEn_q, fbRdEn_d;
  logic        inWinD2_q, inWinD2_d;
  logic        synced_q, synced_d;
  rgb_t        rgb_q, rgb_d;

  // Decisions are taken for the column three edges ahead, wrapping at the end of the line.
  assign cxSum     = cx + 10'(LOOKAHEAD);
  assign cxLa      = (cxSum >= HTotal) ? cxSum - HTotal : cxSum;
  assign xInWin    = (cxLa >= WinX0) && (cxLa < WinX1);
  assign yInWin    = (cy >= WinY0) && (cy < WinY1);
  assign inWin     = xInWin && yInWin && synced_q;
  assign lineStart = (cx == 10'd0);
  assign yLoad     = lineStart && (cy == WinY0);
  assign yAdvance  = lineStart && (cy > WinY0) && (cy < WinY1);

  gb_scale_counter u_xCounter (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .load_i    (cxLa == WinX0),
    .advance_i (xInWin && yInWin),
    .count_o   (gbX),
    .sub_o     (xSub)
  );

  gb_scale_counter u_yCounter (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .load_i    (yLoad),
    .advance_i (yAdvance),
    .count_o   (gbY),
    .sub_o     (ySub)
  );

  assign unusedSubs = ^{xSub, ySub};

  // Output stays at border until a frame start has been seen, so a reset never exposes a torn frame.
  always_comb begin
    fbRdAddr_d = {gbY, gbX};
    fbRdEn_d   = inWin;
    inWinD2_d  = fbRdEn_q;
    synced_d   = synced_q | yLoad;
    rgb_d      = inWinD2_q ? Palette[fb.fb_rd_data] : BORDER_RGB;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      fbRdAddr_q <= '0;
      fbRdEn_q   <= 1'b0;
      inWinD2_q  <= 1'b0;
      synced_q   <= 1'b0;
      rgb_q      <= 24'h000000;
    end else begin
      fbRdAddr_q <= fbRdAddr_d;
      fbRdEn_q   <= fbRdEn_d;
      inWinD2_q  <= inWinD2_d;
      synced_q   <= synced_d;
      rgb_q      <= rgb_d;
    end
  end

  assign fb.fb_rd_addr = fbRdAddr_q;
  assign fb.fb_rd_en   = fbRdEn_q;
  assign rgb           = rgb_q;

endmodule
